// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, ALU opcodes and the sequential multiplier state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR
    } aluop_t;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_STEP,
        MS_DONE
    } mulstate_t;

    localparam int MUL_STEPS = 32;

endpackage

// File: rtl/alu_if.sv
// Connection bundle between the shared ALU and whichever unit is driving it.
interface alu_if;
    import cpu_types_pkg::*;

    aluop_t ALUOP;
    word_t  port_a;
    word_t  port_b;
    word_t  port_out;
    logic   zero;
    logic   neg;

    modport tb  (output ALUOP, port_a, port_b, input port_out, zero, neg);
    modport alu (input ALUOP, port_a, port_b, output port_out, zero, neg);

endinterface

// File: rtl/alu.sv
// Shared combinational ALU used in the execute stage; no carry flag is produced.
module alu
    import cpu_types_pkg::*;
(
    alu_if.alu aluif
);

    word_t res;

    always_comb begin
        res = '0;
        case (aluif.ALUOP)
            ALU_ADD: res = aluif.port_a + aluif.port_b;
            ALU_SUB: res = aluif.port_a - aluif.port_b;
            ALU_AND: res = aluif.port_a & aluif.port_b;
            ALU_OR:  res = aluif.port_a | aluif.port_b;
            ALU_XOR: res = aluif.port_a ^ aluif.port_b;
            default: res = '0;
        endcase
    end

    always_comb begin
        aluif.port_out = res;
        aluif.zero     = (res == '0);
        aluif.neg      = res[31];
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential 32x32->64 unsigned shift-and-add multiplier that borrows the shared ALU for its adds.
// Optional build macro ZERO_SKIP_EN: a zero operand finishes immediately with a zero product.
module alu_mul_seq
    import cpu_types_pkg::*;
#(
    parameter int STEPS = MUL_STEPS
)
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  start,
    input  word_t mcand,
    input  word_t mplier,
    output logic  busy,
    output logic  done,
    output word_t product_hi,
    output word_t product_lo,
    output logic  hi_nz,
    alu_if.tb     aluif
);

    mulstate_t   state_q, state_d;
    word_t       hi_q, hi_d;
    word_t       lo_q, lo_d;
    word_t       mc_q, mc_d;
    word_t       product_hi_q, product_hi_d;
    word_t       product_lo_q, product_lo_d;
    logic [4:0]  cnt_q, cnt_d;
    word_t       sum;
    logic        carry;

    // The ALU has no carry flag, so recover it from the operand and sum MSBs.
    function automatic logic carry_out(input logic a, input logic b, input logic s);
        return (a & b) | ((a | b) & ~s);
    endfunction

    always_comb begin
        aluif.ALUOP  = ALU_ADD;
        aluif.port_a = '0;
        aluif.port_b = '0;
        if (state_q == MS_STEP) begin
            aluif.port_a = hi_q;
            aluif.port_b = lo_q[0] ? mc_q : '0;
        end
    end

    always_comb begin
        sum   = aluif.port_out;
        carry = lo_q[0] & carry_out(hi_q[31], mc_q[31], sum[31]);
    end

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        mc_d         = mc_q;
        cnt_d        = cnt_q;
        product_hi_d = product_hi_q;
        product_lo_d = product_lo_q;
        case (state_q)
            MS_IDLE: begin
                if (start) begin
                    state_d = MS_STEP;
                    hi_d    = '0;
                    lo_d    = mplier;
                    mc_d    = mcand;
                    cnt_d   = '0;
`ifdef ZERO_SKIP_EN
                    if (mcand == '0 || mplier == '0) begin
                        state_d      = MS_DONE;
                        product_hi_d = '0;
                        product_lo_d = '0;
                    end
`endif
                end
            end
            MS_STEP: begin
                {hi_d, lo_d} = {carry, sum, lo_q[31:1]};
                cnt_d        = cnt_q + 5'd1;
                if (cnt_q == 5'(STEPS - 1)) begin
                    state_d      = MS_DONE;
                    product_hi_d = hi_d;
                    product_lo_d = lo_d;
                end
            end
            MS_DONE: state_d = MS_IDLE;
            default: state_d = MS_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= MS_IDLE;
            hi_q         <= '0;
            lo_q         <= '0;
            mc_q         <= '0;
            cnt_q        <= '0;
            product_hi_q <= '0;
            product_lo_q <= '0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            mc_q         <= mc_d;
            cnt_q        <= cnt_d;
            product_hi_q <= product_hi_d;
            product_lo_q <= product_lo_d;
        end
    end

    always_comb begin
        busy       = (state_q == MS_STEP) || (state_q == MS_DONE);
        done       = (state_q == MS_DONE);
        product_hi = product_hi_q;
        product_lo = product_lo_q;
        hi_nz      = (product_hi_q != '0);
    end

endmodule
